// File: rtl/atomrvcore_pkg.sv
// Shared constants and types for the atomRV instruction fetch unit.
package atomrvcore_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_RUN,
    ST_FLUSH
  } fetch_state_e;

  typedef enum logic [1:0] {
    REDIR_NONE,
    REDIR_BRANCH,
    REDIR_JAL,
    REDIR_JALR
  } redir_kind_e;

  // JALR outranks JAL, which outranks a taken branch.
  function automatic redir_kind_e redir_kind(input logic be, input logic uje, input logic jalre);
    if (jalre)    return REDIR_JALR;
    else if (uje) return REDIR_JAL;
    else if (be)  return REDIR_BRANCH;
    else          return REDIR_NONE;
  endfunction

endpackage

// File: rtl/atomrvcore_ifu_fifo.sv
// Synchronous instruction buffer holding {instruction, PC} pairs; registered head,
// simultaneous push and pop allowed at any occupancy, flush empties it in one edge.
module atomrvcore_ifu_fifo #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] instr_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] pc_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] instr_mem_q [DEPTH];
  logic [WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign instr_o = instr_mem_q[rd_ptr_q];
  assign pc_o    = pc_mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // NOTE: every variable assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define which
  // entries are live, and leaving the array out of reset keeps it a plain RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      instr_mem_q[wr_ptr_q] <= instr_i;
      pc_mem_q[wr_ptr_q]    <= pc_i;
    end
  end

endmodule

// File: rtl/atomrvcore_ifu.sv
// Instruction fetch unit: owns the PC, issues word fetches, buffers returned
// instructions for decode and applies branch/JAL/JALR redirects.
module atomrvcore_ifu
  import atomrvcore_pkg::*;
#(
  parameter  int unsigned          DATAWIDTH  = INSTR_WIDTH,
  parameter  logic [DATAWIDTH-1:0] RESET_PC   = DATAWIDTH'(RESET_PC_DEFAULT),
  parameter  int unsigned          FIFO_DEPTH = 2,
  localparam int unsigned          PTR_W      = $clog2(FIFO_DEPTH),
  localparam int unsigned          CNT_W      = PTR_W + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 imem_req_o,
  output logic [DATAWIDTH-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [DATAWIDTH-1:0] imem_rdata_i,
  input  logic                 BE_i,
  input  logic                 UJE_i,
  input  logic                 JALRE_i,
  input  logic [DATAWIDTH-1:0] redir_pc_i,
  input  logic [DATAWIDTH-1:0] immed_i,
  input  logic [DATAWIDTH-1:0] alu_result_i,
  output logic [DATAWIDTH-1:0] instr_o,
  output logic [DATAWIDTH-1:0] pc_o,
  output logic                 instr_valid_o,
  input  logic                 stall_i
);

  fetch_state_e         state_q, state_d;
  logic [DATAWIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]     outst_q, outst_d;
  logic [CNT_W-1:0]     drop_q, drop_d;

  // Address of every issued-but-unreturned request, in issue order.
  logic [DATAWIDTH-1:0] req_pc_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     rq_wr_q, rq_rd_q;

  redir_kind_e          kind;
  logic                 active, redirect, rsp_valid, keep, pop, accept, credit_ok;
  logic [DATAWIDTH-1:0] target;
  logic [CNT_W:0]       credit_used;

  logic [DATAWIDTH-1:0] fifo_instr, fifo_pc;
  logic                 fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_count;

  assign active    = (state_q != ST_RESET);
  assign kind      = redir_kind(BE_i, UJE_i, JALRE_i);
  assign redirect  = active && (kind != REDIR_NONE);
  // A response with nothing outstanding is a leftover from before a reset.
  assign rsp_valid = imem_rvalid_i && (outst_q != '0);
  assign keep      = rsp_valid && (drop_q == '0) && !redirect;

  assign instr_valid_o = ~fifo_empty;
  assign instr_o       = instr_valid_o ? fifo_instr : '0;
  assign pc_o          = instr_valid_o ? fifo_pc : '0;
  assign pop           = instr_valid_o & ~stall_i;

  assign imem_addr_o = {pc_q[DATAWIDTH-1:2], 2'b00};
  assign accept      = imem_req_o & imem_gnt_i;

  always_comb begin
    target = pc_q;
    unique case (kind)
      REDIR_JALR:              target = {alu_result_i[DATAWIDTH-1:1], 1'b0};
      REDIR_JAL, REDIR_BRANCH: target = redir_pc_i + (immed_i << 1);
      default:                 target = pc_q;
    endcase
  end

  // Slots are in flight plus buffered; an entry leaving this cycle frees its slot
  // in time for the response to a request issued now, giving one fetch per cycle.
  always_comb begin
    credit_used = {1'b0, outst_q} + {1'b0, fifo_count} - (CNT_W + 1)'(pop);
    credit_ok   = credit_used < (CNT_W + 1)'(FIFO_DEPTH);
    imem_req_o  = active && !redirect && credit_ok;
  end

  always_comb begin
    pc_d    = pc_q;
    outst_d = outst_q + CNT_W'(accept) - CNT_W'(rsp_valid);
    drop_d  = drop_q;
    state_d = state_q;

    if (redirect)          pc_d = target;
    else if (accept)       pc_d = pc_q + DATAWIDTH'(4);

    if (redirect)          drop_d = outst_q - CNT_W'(rsp_valid);
    else if (rsp_valid && drop_q != '0) drop_d = drop_q - CNT_W'(1);

    unique case (state_q)
      ST_RESET: state_d = ST_RUN;
      ST_RUN, ST_FLUSH: begin
        if (redirect)                state_d = (drop_d != '0) ? ST_FLUSH : ST_RUN;
        else if (drop_d == '0)       state_d = ST_RUN;
      end
      default:  state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RESET;
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
      rq_wr_q <= '0;
      rq_rd_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      if (accept)    rq_wr_q <= rq_wr_q + PTR_W'(1);
      if (rsp_valid) rq_rd_q <= rq_rd_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) req_pc_q[rq_wr_q] <= imem_addr_o;
  end

  atomrvcore_ifu_fifo #(
    .WIDTH (DATAWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect),
    .push_i  (keep),
    .instr_i (imem_rdata_i),
    .pc_i    (req_pc_q[rq_rd_q]),
    .pop_i   (pop),
    .instr_o (fifo_instr),
    .pc_o    (fifo_pc),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: doc/atomrvcore_ifu.md
# atomRVCORE_ifu

Instruction fetch unit sitting directly upstream of the decode stage. It owns the program counter, issues word requests to instruction memory, buffers returned instructions with their PCs in a small FIFO, and presents them to decode under a valid/stall handshake. It also applies branch, JAL and JALR redirects fed back from decode/execute, flushing wrong-path instructions.

## Interface
Parameters:
- DATAWIDTH, 32, instruction/address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2); also the max outstanding requests

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset, synchronous, active-high
- imem_req_o  out  1  fetch request
- imem_addr_o  out  DATAWIDTH  word-aligned fetch address
- imem_gnt_i  in  1  request accepted this cycle when req&gnt
- imem_rvalid_i  in  1  response valid; exactly one cycle after the accepting grant, in order
- imem_rdata_i  in  DATAWIDTH  returned instruction
- BE_i  in  1  taken conditional branch
- UJE_i  in  1  JAL
- JALRE_i  in  1  JALR
- redir_pc_i  in  DATAWIDTH  PC of the redirecting instruction
- immed_i  in  DATAWIDTH  sign-extended offset, in halfwords (imm[N:1])
- alu_result_i  in  DATAWIDTH  JALR target (rs1+imm)
- instr_o  out  DATAWIDTH  instruction to decode
- pc_o  out  DATAWIDTH  PC of instr_o
- instr_valid_o  out  1  instr_o/pc_o valid
- stall_i  in  1  decode cannot accept; head held

## Operation
- States: RESET (held while rst_i), RUN, FLUSH. RESET→RUN on first cycle rst_i=0. RUN→FLUSH on redirect with drop_cnt≠0 after update; FLUSH→RUN when drop_cnt reaches 0. Redirect in FLUSH re-arms drop_cnt and stays in FLUSH.
- Redirect = BE_i|UJE_i|JALRE_i; priority JALRE_i > UJE_i > BE_i. Targets: JALR = alu_result_i & ~1; JAL/branch = redir_pc_i + (immed_i<<1), modulo 2^DATAWIDTH. Target bits [1:0] forced to 0 on the address bus.
- Redirect cycle: pc_q <= target; FIFO emptied; drop_cnt <= responses in flight after this edge (issued-not-returned, excluding one returning this cycle); no request issued this cycle.
- Issue in RUN/FLUSH when no redirect and (outstanding + occupancy) < FIFO_DEPTH: imem_req_o=1, imem_addr_o=pc_q. On req&gnt: pc_q <= pc_q+4 (wraps at 2^DATAWIDTH), outstanding++. Requests after redirect use the new PC even while FLUSH drops old responses.
- Response: if drop_cnt≠0, discard and drop_cnt--; else push {imem_rdata_i, addr} into FIFO (addr tracked in a PC-of-request queue). outstanding-- on every rvalid.
- Pop when instr_valid_o & ~stall_i. Push and pop in same cycle allowed at any occupancy, including full.
- Response arriving in a redirect cycle is always discarded.

## Timing
- Reset values: imem_req_o=0, imem_addr_o=RESET_PC, instr_o=0, pc_o=0, instr_valid_o=0; pc_q=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state RESET.
- First request: cycle after rst_i falls, addr RESET_PC.
- Latency grant→instr_valid_o: 2 cycles (rvalid at +1, visible at +2, registered FIFO head).
- Steady state with gnt=1, stall_i=0: one instruction per cycle.
- Redirect at cycle t: first target-path request at t+1; earliest target instruction on instr_valid_o at t+3. instr_valid_o=0 from t+1 until then.
- stall_i held: instr_o/pc_o stable; req drops when credit exhausted.
- rst_i mid-operation: next edge restores all reset values; in-flight responses after reset are ignored (outstanding cleared; rvalid with outstanding=0 ignored).

## Structure
- Shared package atomRVCORE_pkg: RESET_PC default, fetch state enum (RESET/RUN/FLUSH), instruction width constant.
- Sub-module atomRVCORE_ifu_fifo: parameterised synchronous FIFO (data+PC), push/pop/flush, full/empty/count; used once.

## Test plan
- Reset release, gnt=1, stall=0: addresses 0x0,0x4,0x8…; first instr_valid_o 2 cycles after first grant with pc_o=0x0, then one per cycle.
- stall_i held 5 cycles with DEPTH=2: FIFO fills to 2, imem_req_o=0, instr_o/pc_o unchanged; release → pc 0x4,0x8 in order, no loss.
- BE_i with redir_pc_i=0x100, immed_i=0x8 while 2 requests outstanding: next addr 0x110, both old responses dropped, first valid pc_o=0x110.
- JALRE_i and BE_i together, alu_result_i=0x203: fetch goes to 0x202→bus 0x200 (JALR wins).
- imem_gnt_i toggled 1/0 randomly 200 cycles: PC sequence contiguous, no duplicate/missing instructions at decode.
- rst_i asserted with response in flight: outputs return to reset values next edge, stale rvalid ignored, refetch from RESET_PC.
